// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - register file access bundle (write ports, read ports, status)
//
// Purpose : groups every non-clock/reset signal of regfile_mp.
// Signals : we0/wa0/wd0  write port 0 (priority)
//           we1/wa1/wd1  write port 1
//           ra           packed read addresses, port k = ra[k*AW +: AW]
//           rd           packed read data,      port k = rd[k*WIDTH +: WIDTH]
//           ready        initialisation finished
//           wr_clash     both write ports hit the same address last cycle
// Modports: master = user of the register file, slave = regfile_mp

interface regfile_mp_if #(
    parameter int WIDTH = 64,
    parameter int AW    = 5,
    parameter int NRD   = 2
);
    logic                 we0;
    logic [AW-1:0]        wa0;
    logic [WIDTH-1:0]     wd0;
    logic                 we1;
    logic [AW-1:0]        wa1;
    logic [WIDTH-1:0]     wd1;
    logic [NRD*AW-1:0]    ra;
    logic [NRD*WIDTH-1:0] rd;
    logic                 ready;
    logic                 wr_clash;

    modport master (
        output we0, wa0, wd0, we1, wa1, wd1, ra,
        input  rd, ready, wr_clash
    );

    modport slave (
        input  we0, wa0, wd0, we1, wa1, wd1, ra,
        output rd, ready, wr_clash
    );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with init engine
//
// Purpose : DEPTH x WIDTH register file, two write ports (port 0 wins on a
//           same-address write), NRD combinational read ports, optional
//           write-to-read bypass, optional hardwired zero entry, and a
//           sequential post-reset initialisation walk that gates all access
//           until ready rises.
// Ports   : clk      rising-edge clock
//           reset_n  asynchronous active-low reset (array contents kept)
//           bus      regfile_mp_if.slave (write ports, read ports, ready,
//                    wr_clash)

module regfile_mp #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 32,
    parameter int NRD       = 2,
    parameter int ZERO_REG  = 31,
    parameter int BYPASS    = 1,
    parameter int INIT_MODE = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    regfile_mp_if.slave  bus
);
    localparam int            AW        = $clog2(DEPTH);
    // ZERO_REG outside the array (e.g. == DEPTH) disables the zero entry.
    localparam bit            ZERO_EN   = (ZERO_REG >= 0) && (ZERO_REG < DEPTH);
    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [AW-1:0]    cnt;
    logic             ready;
    logic             init_we;
    logic [WIDTH-1:0] init_val;
    logic             wr0;
    logic             wr1;
    logic             clash_nxt;
    logic             clash_q;
    logic [NRD*WIDTH-1:0] rd_int;

    logic [WIDTH-1:0] mem [DEPTH];

    function automatic logic is_zero(input logic [AW-1:0] a);
        return ZERO_EN && (a == ZERO_ADDR);
    endfunction

    // ------------------------------------------------------------------
    // Init / run FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && cnt == LAST_ADDR) begin
            state_nxt = ST_RUN;
        end
    end

    // reset_n gates init_we so an edge seen while reset is held does not
    // write entry 0 early; the walk only counts edges after release.
    always_comb begin
        ready   = (state == ST_RUN);
        init_we = (state == ST_INIT) && reset_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state == ST_INIT) begin
            cnt <= cnt + AW'(1);
        end
    end

    assign init_val = (INIT_MODE == 1) ? WIDTH'(cnt) : '0;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    assign wr0 = ready && bus.we0 && !is_zero(bus.wa0);
    // Port 1 is dropped outright on a same-address write so storage
    // matches the port-0 priority of the bypass path.
    assign wr1 = ready && bus.we1 && !is_zero(bus.wa1)
                 && !(wr0 && (bus.wa0 == bus.wa1));

    always_ff @(posedge clk) begin
        if (init_we) begin
            if (!is_zero(cnt)) begin
                mem[cnt] <= init_val;
            end
        end else begin
            if (wr1) begin
                mem[bus.wa1] <= bus.wd1;
            end
            if (wr0) begin
                mem[bus.wa0] <= bus.wd0;
            end
        end
    end

    // A clash on the zero entry is not reported: both writes vanish anyway.
    assign clash_nxt = ready && bus.we0 && bus.we1
                       && (bus.wa0 == bus.wa1) && !is_zero(bus.wa0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clash_q <= 1'b0;
        end else begin
            clash_q <= clash_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    always_comb begin : rd_mux
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] word;
        rd_int = '0;
        addr   = '0;
        word   = '0;
        for (int k = 0; k < NRD; k++) begin
            addr = bus.ra[k*AW +: AW];
            word = mem[addr];
            if (BYPASS != 0) begin
                // Port 0 checked last so it overrides port 1, as in storage.
                if (bus.we1 && bus.wa1 == addr) begin
                    word = bus.wd1;
                end
                if (bus.we0 && bus.wa0 == addr) begin
                    word = bus.wd0;
                end
            end
            if (!ready || is_zero(addr)) begin
                word = '0;
            end
            rd_int[k*WIDTH +: WIDTH] = word;
        end
    end

    assign bus.rd       = rd_int;
    assign bus.ready    = ready;
    assign bus.wr_clash = clash_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp

module tb_regfile_mp;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    regfile_mp_if #(.WIDTH(64), .AW(5), .NRD(2)) bb ();
    regfile_mp_if #(.WIDTH(32), .AW(4), .NRD(4)) sb ();

    regfile_mp #(
        .WIDTH(64), .DEPTH(32), .NRD(2), .ZERO_REG(31), .BYPASS(1), .INIT_MODE(1)
    ) u_big (
        .clk(clk), .reset_n(rst_n), .bus(bb)
    );

    regfile_mp #(
        .WIDTH(32), .DEPTH(16), .NRD(4), .ZERO_REG(16), .BYPASS(0), .INIT_MODE(0)
    ) u_small (
        .clk(clk), .reset_n(rst_n), .bus(sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bb.we0 = 1'b0; bb.wa0 = '0; bb.wd0 = '0;
        bb.we1 = 1'b0; bb.wa1 = '0; bb.wd1 = '0;
        bb.ra  = '0;
        sb.we0 = 1'b0; sb.wa0 = '0; sb.wd0 = '0;
        sb.we1 = 1'b0; sb.wa1 = '0; sb.wd1 = '0;
        sb.ra  = '0;

        #12;
        bb.ra = {5'd6, 5'd5};
        #1;
        chk("rst_ready_big",   64'(bb.ready), 64'd0);
        chk("rst_ready_small", 64'(sb.ready), 64'd0);
        chk("rst_clash",       64'(bb.wr_clash), 64'd0);
        chk("rst_rd_big",      bb.rd[63:0], 64'd0);

        // Release reset; writes attempted during init must be ignored.
        rst_n  = 1'b1;
        bb.we0 = 1'b1; bb.wa0 = 5'd5; bb.wd0 = 64'h123;
        for (int i = 1; i <= 32; i++) begin
            edge1();
            if (i == 32) bb.we0 = 1'b0;
            chk("init_ready_big",   64'(bb.ready), 64'(i >= 32));
            chk("init_ready_small", 64'(sb.ready), 64'(i >= 16));
            if (i == 31) chk("init_rd_big", bb.rd[63:0], 64'd0);
        end

        bb.ra = {5'd31, 5'd5};
        #1;
        chk("run_rd5",  bb.rd[63:0],   64'd5);
        chk("run_rd31", bb.rd[127:64], 64'd0);
        bb.ra = {5'd30, 5'd0};
        #1;
        chk("run_rd0",  bb.rd[63:0],   64'd0);
        chk("run_rd30", bb.rd[127:64], 64'd30);

        sb.ra = {4'd3, 4'd2, 4'd1, 4'd0};
        #1;
        for (int k = 0; k < 4; k++) chk("small_init_zero", 64'(sb.rd[k*32 +: 32]), 64'd0);

        // Same-cycle write/read: bypass on big, old data on small.
        bb.we0 = 1'b1; bb.wa0 = 5'd3; bb.wd0 = 64'hDEAD_BEEF;
        bb.ra  = {5'd4, 5'd3};
        sb.we0 = 1'b1; sb.wa0 = 4'd3; sb.wd0 = 32'hDEAD_BEEF;
        sb.ra  = {4'd0, 4'd0, 4'd0, 4'd3};
        #1;
        chk("byp_same_cycle", bb.rd[63:0],   64'hDEAD_BEEF);
        chk("byp_other_port", bb.rd[127:64], 64'd4);
        chk("nobyp_old_data", 64'(sb.rd[31:0]), 64'd0);
        edge1();
        bb.we0 = 1'b0;
        sb.we0 = 1'b0;
        #1;
        chk("byp_after_edge",   bb.rd[63:0], 64'hDEAD_BEEF);
        chk("nobyp_after_edge", 64'(sb.rd[31:0]), 64'hDEAD_BEEF);

        // Same-address double write.
        bb.we0 = 1'b1; bb.wa0 = 5'd7; bb.wd0 = 64'hAA;
        bb.we1 = 1'b1; bb.wa1 = 5'd7; bb.wd1 = 64'hBB;
        bb.ra  = {5'd8, 5'd7};
        #1;
        chk("clash_byp_prio", bb.rd[63:0], 64'hAA);
        chk("clash_pre",      64'(bb.wr_clash), 64'd0);
        edge1();
        bb.we0 = 1'b0;
        bb.wa1 = 5'd8; bb.wd1 = 64'hCC;
        #1;
        chk("clash_flag",    64'(bb.wr_clash), 64'd1);
        chk("clash_stored",  bb.rd[63:0],   64'hAA);
        chk("port1_bypass",  bb.rd[127:64], 64'hCC);
        edge1();
        bb.we1 = 1'b0;
        #1;
        chk("clash_cleared", 64'(bb.wr_clash), 64'd0);
        chk("port1_stored",  bb.rd[127:64], 64'hCC);
        chk("entry7_kept",   bb.rd[63:0],   64'hAA);

        // Writes to the zero entry are dropped and never flagged.
        bb.we0 = 1'b1; bb.wa0 = 5'd31; bb.wd0 = 64'hFF;
        bb.we1 = 1'b1; bb.wa1 = 5'd31; bb.wd1 = 64'hEE;
        bb.ra  = {5'd30, 5'd31};
        #1;
        chk("zero_same_cycle", bb.rd[63:0],   64'd0);
        chk("zero_neighbour",  bb.rd[127:64], 64'd30);
        edge1();
        bb.we0 = 1'b0;
        bb.we1 = 1'b0;
        #1;
        chk("zero_after",      bb.rd[63:0],   64'd0);
        chk("zero_neigh_after", bb.rd[127:64], 64'd30);
        chk("zero_no_clash",   64'(bb.wr_clash), 64'd0);

        // Small instance: two writes, four-port readback.
        sb.we0 = 1'b1; sb.wa0 = 4'd9;  sb.wd0 = 32'h1111;
        sb.we1 = 1'b1; sb.wa1 = 4'd10; sb.wd1 = 32'h2222;
        edge1();
        sb.we0 = 1'b0;
        sb.we1 = 1'b0;
        sb.ra  = {4'd3, 4'd9, 4'd10, 4'd9};
        #1;
        chk("small_rb_p0", 64'(sb.rd[31:0]),   64'h1111);
        chk("small_rb_p1", 64'(sb.rd[63:32]),  64'h2222);
        chk("small_rb_p2", 64'(sb.rd[95:64]),  64'h1111);
        chk("small_rb_p3", 64'(sb.rd[127:96]), 64'hDEAD_BEEF);

        // Reset during RUN, then again part-way through init.
        bb.ra = {5'd7, 5'd5};
        rst_n = 1'b0;
        #1;
        chk("rerun_ready", 64'(bb.ready), 64'd0);
        chk("rerun_rd",    bb.rd[63:0],   64'd0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_init_ready", 64'(bb.ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(bb.ready), 64'd0);
        chk("mid_rst_rd",    bb.rd[127:64], 64'd0);
        rst_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            edge1();
            chk("reinit_ready", 64'(bb.ready), 64'(i >= 32));
        end
        #1;
        chk("reinit_rd5",  bb.rd[63:0],   64'd5);
        chk("reinit_rd7",  bb.rd[127:64], 64'd7);
        chk("reinit_small", 64'(sb.rd[31:0]), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
